// File: rtl/count_seq_if.sv
// count_seq_if: control inputs and count/status outputs between the buttons and count_sequencer.
interface count_seq_if #(parameter int WIDTH = 3);
  logic             start;
  logic             stop;
  logic             pause;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             done;
  logic [1:0]       state;
  modport master (output start, stop, pause, terminal, input count, running, done, state);
  modport slave  (input start, stop, pause, terminal, output count, running, done, state);
endinterface

// File: rtl/count_sequencer.sv
// count_sequencer: run/stop/pause up-counter with prescaled tick and one-cycle done pulse.
// Define COUNT_SEQ_AUTORELOAD_EN for periodic mode (wrap to 0 on terminal instead of DONE).
module count_sequencer #(
  parameter int WIDTH    = 3,
  parameter int TICK_DIV = 50_000_000
) (
  input logic        clk,
  input logic        reset,
  count_seq_if.slave bus
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, term_q, term_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d, running_q;
  logic             tick;
  assign tick = presc_q == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      term_q    <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      term_q    <= term_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= state_d == RUN;
    end
  end
  // Priority: stop > start > pause > tick; prescaler only advances while running.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      count_d = '0;
      presc_d = '0;
    end else if (bus.start) begin
      state_d = RUN;
      count_d = '0;
      term_d  = bus.terminal;
      presc_d = '0;
    end else if (state_q == RUN && bus.pause) begin
      state_d = PAUSE;
    end else if (state_q == RUN && tick) begin
      presc_d = '0;
      if (count_q == term_q) begin
        done_d = 1'b1;
`ifdef COUNT_SEQ_AUTORELOAD_EN
        count_d = '0;
`else
        state_d = DONE;
`endif
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (state_q == RUN) begin
      presc_d = presc_q + 1'b1;
    end else if (state_q == PAUSE && !bus.pause) begin
      state_d = RUN;
    end
  end
  assign bus.count   = count_q;
  assign bus.state   = state_q;
  assign bus.done    = done_q;
  assign bus.running = running_q;
endmodule
